usb_crc_engine: RTL and testbench

- Parametrised serial CRC engine for the USB packet path. Serves as the successor to the fixed CRC16 generator.
- Width, polynomial, seed and residual are set by parameters, so one module covers CRC5 (tokens) and CRC16 (data).
- Two modes:
  - Generate mode: accumulates the bit stream, then streams out the complemented remainder.
  - Check mode: accumulates the data bits plus the received CRC bits, then compares the register against the residual.

---
 rtl/usb_crc_engine.sv | 140 ++++++++++++++
 tb/tb_usb_crc_engine.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_crc_engine.sv
// Parametrised serial CRC generator/checker for USB tokens (CRC5) and data (CRC16).
// Optional length check via `USB_CRC_LENCHK_EN` (adds bit_count/len_err ports).
module usb_crc_engine #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] POLY     = 16'h8005,
   parameter logic [WIDTH-1:0] SEED     = '1,
   parameter logic [WIDTH-1:0] RESIDUAL = 16'h800D,
   parameter int               CNT_W    = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode_chk,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             bit_last,
   input  logic             out_en,
   output logic             crc_out,
   output logic             crc_out_valid,
   output logic [WIDTH-1:0] crc_val,
   output logic             busy,
   output logic             done,
   output logic             crc_ok,
   output logic             crc_err
`ifdef USB_CRC_LENCHK_EN
   ,
   output logic [CNT_W-1:0] bit_count,
   output logic             len_err
`endif
);

   localparam int IW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_EMIT, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] crc_reg, reg_upd, reg_end, emit_sr;
   logic [IW-1:0]    emit_idx;
   logic             mode_q;
   logic             accum_end, emit_last, ok_nxt;

   assign reg_upd   = {crc_reg[WIDTH-2:0], 1'b0} ^ ((crc_reg[WIDTH-1] ^ bit_in) ? POLY : '0);
   // bit_last without bit_valid closes the packet on the current register
   assign reg_end   = bit_valid ? reg_upd : crc_reg;
   assign accum_end = (state == S_ACCUM) && bit_last && !start;
   assign emit_last = (state == S_EMIT) && out_en && (emit_idx == IW'(WIDTH - 1));

`ifdef USB_CRC_LENCHK_EN
   logic [CNT_W-1:0] cnt_end;
   logic             len_nxt;

   assign cnt_end = (bit_valid && (bit_count != '1)) ? bit_count + 1'b1 : bit_count;
   assign len_nxt = (32'(cnt_end) < WIDTH);
   assign ok_nxt  = (reg_end == RESIDUAL) && !len_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_count <= '0;
         len_err   <= 1'b0;
      end else if (start) begin
         bit_count <= '0;
         len_err   <= 1'b0;
      end else if (state == S_ACCUM) begin
         bit_count <= cnt_end;
         if (bit_last && mode_q)
            len_err <= len_nxt;
      end
   end
`else
   assign ok_nxt = (reg_end == RESIDUAL);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = S_IDLE;
         S_ACCUM: if (accum_end) state_nxt = mode_q ? S_DONE : S_EMIT;
         S_EMIT:  if (emit_last) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // start aborts whatever is in flight, including a pending bit
      if (start)
         state_nxt = S_ACCUM;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_reg  <= SEED;
         crc_val  <= '0;
         emit_sr  <= '0;
         emit_idx <= '0;
         mode_q   <= 1'b0;
         crc_ok   <= 1'b0;
         crc_err  <= 1'b0;
      end else if (start) begin
         crc_reg  <= SEED;
         mode_q   <= mode_chk;
         emit_idx <= '0;
         crc_ok   <= 1'b0;
         crc_err  <= 1'b0;
      end else begin
         case (state)
            S_ACCUM: begin
               if (bit_valid)
                  crc_reg <= reg_upd;
               if (bit_last) begin
                  crc_val  <= ~reg_end;
                  emit_sr  <= ~reg_end;
                  emit_idx <= '0;
                  if (mode_q) begin
                     crc_ok  <= ok_nxt;
                     crc_err <= !ok_nxt;
                  end
               end
            end
            S_EMIT: begin
               if (out_en) begin
                  emit_sr  <= {emit_sr[WIDTH-2:0], 1'b0};
                  emit_idx <= emit_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign crc_out       = (state == S_EMIT) && emit_sr[WIDTH-1];
   assign crc_out_valid = (state == S_EMIT) && out_en;
   assign busy          = (state != S_IDLE);
   assign done          = (state == S_DONE);

endmodule

// File: tb/tb_usb_crc_engine.sv
// Scoreboard bench for usb_crc_engine: CRC5 and CRC16 instances, generate/check, stall, abort, reset.
module tb_usb_crc_engine;

   logic clk = 1'b0, rst = 1'b1;
   logic start = 1'b0, mode_chk = 1'b0, bit_valid = 1'b0, bit_in = 1'b0, bit_last = 1'b0, out_en = 1'b0;
   logic sel = 1'b0;
   logic start5, start16;

   logic        o5_out, o5_vld, o5_busy, o5_done, o5_ok, o5_err;
   logic [4:0]  o5_val;
   logic        o16_out, o16_vld, o16_busy, o16_done, o16_ok, o16_err;
   logic [15:0] o16_val;
`ifdef USB_CRC_LENCHK_EN
   logic [10:0] o5_cnt, o16_cnt;
   logic        o5_len, o16_len;
`endif

   int total = 0, bad = 0;
   int vld_cnt = 0, vld_bad = 0;
   logic       exp_bits[$];
   logic [1:0] exp_res[$];

   assign start5  = start & ~sel;
   assign start16 = start & sel;

   usb_crc_engine #(.WIDTH(5), .POLY(5'h05), .SEED(5'h1F), .RESIDUAL(5'h0C), .CNT_W(11)) u5 (
      .clk(clk), .rst(rst), .start(start5), .mode_chk(mode_chk), .bit_valid(bit_valid),
      .bit_in(bit_in), .bit_last(bit_last), .out_en(out_en), .crc_out(o5_out),
      .crc_out_valid(o5_vld), .crc_val(o5_val), .busy(o5_busy), .done(o5_done),
      .crc_ok(o5_ok), .crc_err(o5_err)
`ifdef USB_CRC_LENCHK_EN
      , .bit_count(o5_cnt), .len_err(o5_len)
`endif
   );

   usb_crc_engine #(.WIDTH(16), .POLY(16'h8005), .SEED(16'hFFFF), .RESIDUAL(16'h800D), .CNT_W(11)) u16 (
      .clk(clk), .rst(rst), .start(start16), .mode_chk(mode_chk), .bit_valid(bit_valid),
      .bit_in(bit_in), .bit_last(bit_last), .out_en(out_en), .crc_out(o16_out),
      .crc_out_valid(o16_vld), .crc_val(o16_val), .busy(o16_busy), .done(o16_done),
      .crc_ok(o16_ok), .crc_err(o16_err)
`ifdef USB_CRC_LENCHK_EN
      , .bit_count(o16_cnt), .len_err(o16_len)
`endif
   );

   always #5 clk = ~clk;

   logic        m_out, m_vld, m_busy, m_done, m_ok, m_err;
   logic [15:0] m_val;
   assign m_out  = sel ? o16_out  : o5_out;
   assign m_vld  = sel ? o16_vld  : o5_vld;
   assign m_busy = sel ? o16_busy : o5_busy;
   assign m_done = sel ? o16_done : o5_done;
   assign m_ok   = sel ? o16_ok   : o5_ok;
   assign m_err  = sel ? o16_err  : o5_err;
   assign m_val  = sel ? o16_val  : {11'b0, o5_val};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_model(input int w, input logic [31:0] poly,
                                             input logic [63:0] bits, input int n);
      logic [31:0] r, mask;
      logic        fb;
      mask = (32'h1 << w) - 32'h1;
      r    = mask;
      for (int i = 0; i < n; i++) begin
         fb = r[w-1] ^ bits[i];
         r  = ((r << 1) & mask) ^ (fb ? poly : 32'h0);
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (m_vld) begin
         vld_cnt++;
         if (!out_en) vld_bad++;
         if (exp_bits.size() == 0) chk("spurious_bit", 32'h1, 32'h0);
         else chk("crc_out", 32'(m_out), 32'(exp_bits.pop_front()));
      end
      if (m_done) begin
         if (exp_res.size() == 0) chk("spurious_done", 32'h1, 32'h0);
         else chk("ok_err", 32'({m_ok, m_err}), 32'(exp_res.pop_front()));
      end
   end

   task automatic drive_bits(input logic s, input logic c, input logic [63:0] bits,
                             input int n, input logic with_last);
      @(posedge clk); #1;
      sel = s; start = 1'b1; mode_chk = c; bit_valid = 1'b0; bit_last = 1'b0; out_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 0) begin
         bit_last = with_last;
         @(posedge clk); #1;
      end else begin
         for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1; bit_in = bits[i]; bit_last = with_last && (i == n - 1);
            @(posedge clk); #1;
         end
      end
      bit_valid = 1'b0; bit_last = 1'b0;
   endtask

   task automatic send_pkt(input logic s, input logic c, input logic [63:0] bits, input int n,
                           input logic stall, output int lat);
      int          w, v0, b0;
      logic [31:0] poly, res, r, g, mask;
      logic        ok, got;
      w    = s ? 16 : 5;
      poly = s ? 32'h8005 : 32'h05;
      res  = s ? 32'h800D : 32'h0C;
      mask = (32'h1 << w) - 32'h1;
      r    = crc_model(w, poly, bits, n);
      g    = ~r & mask;
      ok   = c && (r == res);
`ifdef USB_CRC_LENCHK_EN
      ok   = ok && (n >= w);
`endif
      if (!c)
         for (int i = 0; i < w; i++) exp_bits.push_back(g[w-1-i]);
      exp_res.push_back({ok, c & ~ok});
      v0 = vld_cnt; b0 = vld_bad;
      drive_bits(s, c, bits, n, 1'b1);
      out_en = !stall;
      lat = 1;
      got = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (m_done) begin
            got = 1'b1;
            break;
         end
         @(posedge clk); #1;
         lat++;
         if (stall) out_en = ~out_en;
      end
      if (!got) chk("done_timeout", 32'h0, 32'h1);
      chk("crc_val", 32'(m_val), g);
      chk("vld_cnt", 32'(vld_cnt - v0), c ? 32'h0 : 32'(w));
      chk("vld_no_en", 32'(vld_bad - b0), 32'h0);
      out_en = 1'b1;
   endtask

   int          lat;
   logic [63:0] rb;

   initial begin
      #12;
      chk("rst_busy", 32'({o5_busy, o16_busy}), 32'h0);
      chk("rst_val", 32'({o5_val, o16_val}), 32'h0);
      chk("rst_outs", 32'({o5_vld, o5_done, o5_ok, o5_err, o16_vld, o16_done, o16_ok, o16_err}), 32'h0);
      @(posedge clk); #1; rst = 1'b0;

      // CRC5 SETUP addr 0 ep 0: golden remainder bits 0,1,0,0,0
      send_pkt(1'b0, 1'b0, 64'h0, 11, 1'b0, lat);
      chk("crc5_gen_val", 32'(o5_val), 32'h08);
      chk("crc5_gen_lat", 32'(lat), 32'd6);

      send_pkt(1'b0, 1'b1, 64'h1000, 16, 1'b0, lat);
      chk("crc5_chk_ok", 32'({o5_ok, o5_err}), 32'h2);
      chk("crc5_chk_lat", 32'(lat), 32'd1);

      send_pkt(1'b0, 1'b1, 64'h1008, 16, 1'b0, lat);
      chk("crc5_flip_err", 32'({o5_ok, o5_err}), 32'h1);

      // CRC16 empty payload and its residual
      send_pkt(1'b1, 1'b0, 64'h0, 0, 1'b0, lat);
      chk("crc16_empty_val", 32'(o16_val), 32'h0);
      chk("crc16_empty_lat", 32'(lat), 32'd17);
      send_pkt(1'b1, 1'b1, 64'h0, 16, 1'b0, lat);
      chk("crc16_resid_ok", 32'({o16_ok, o16_err}), 32'h2);

      // random payloads, unstalled then stalled
      rb = {40'h0, 24'($urandom)};
      send_pkt(1'b1, 1'b0, rb, 24, 1'b0, lat);
      chk("crc16_rnd_lat", 32'(lat), 32'd17);
      send_pkt(1'b1, 1'b0, rb, 24, 1'b1, lat);
      chk("crc16_stall_lat", 32'(lat), 32'd33);
      send_pkt(1'b0, 1'b0, 64'h0, 11, 1'b1, lat);
      chk("crc5_stall_lat", 32'(lat), 32'd11);
      rb = {$urandom, $urandom};
      send_pkt(1'b1, 1'b1, rb, 40, 1'b0, lat);

      // abort mid-ACCUM: only the second packet may complete
      drive_bits(1'b1, 1'b0, 64'hABCD, 10, 1'b0);
      rb = {32'h0, $urandom};
      send_pkt(1'b1, 1'b0, rb, 32, 1'b0, lat);
      chk("abort_lat", 32'(lat), 32'd17);

      // async reset while emitting
      for (int i = 0; i < 16; i++) exp_bits.push_back(1'b0);
      exp_res.push_back(2'b00);
      drive_bits(1'b1, 1'b0, 64'h0, 0, 1'b1);
      out_en = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_emit_vld", 32'(o16_vld), 32'h0);
      chk("rst_emit_busy", 32'(o16_busy), 32'h0);
      exp_bits.delete();
      exp_res.delete();
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("rst_emit_val", 32'(o16_val), 32'h0);
      chk("rst_emit_done", 32'(o16_done), 32'h0);

`ifdef USB_CRC_LENCHK_EN
      send_pkt(1'b0, 1'b1, 64'h5, 3, 1'b0, lat);
      chk("len_cnt", 32'(o5_cnt), 32'd3);
      chk("len_err", 32'(o5_len), 32'h1);
      chk("len_ok", 32'(o5_ok), 32'h0);
      send_pkt(1'b0, 1'b0, 64'h5, 3, 1'b0, lat);
      chk("len_gen", 32'(o5_len), 32'h0);
`endif

      repeat (3) @(posedge clk);
      chk("left_bits", 32'(exp_bits.size()), 32'h0);
      chk("left_res", 32'(exp_res.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
